// File: rtl/int_issue_reader.sv
// Read end of the integer issue queue: pop, read regs, execute, write back.
// Define ISSUE_MUL_EN to add MUL/MULH/MULHSU/MULHU on funct7=0000001.
module int_issue_reader #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            iq_empty,
  input  logic [XLEN-1:0] iq_data,
  output logic            iq_deq,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            busy,
  output logic [31:0]     issue_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_q;
  logic            illegal_q;
  logic [31:0]     cnt;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            is_op;
  logic            is_imm;
  logic            is_lui;
  logic            ill;
  logic [XLEN-1:0] res;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u  = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
  assign is_op  = (opcode == 7'b0110011);
  assign is_imm = (opcode == 7'b0010011);
  assign is_lui = (opcode == 7'b0110111);

  function automatic logic [XLEN-1:0] alu(
    input logic [2:0]      f,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic            alt
  );
    logic [XLEN-1:0]        r;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    r  = '0;
    case (f)
      3'b000: r = alt ? a - b : a + b;
      3'b001: r = a << b[4:0];
      3'b010: r = {{(XLEN-1){1'b0}}, sa < sb};
      3'b011: r = {{(XLEN-1){1'b0}}, a < b};
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = sa >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

`ifdef ISSUE_MUL_EN
  // Sign-extend per variant so one 2*XLEN product covers all four ops
  function automatic logic [XLEN-1:0] mul(
    input logic [1:0]      f,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [2*XLEN-1:0] ax;
    logic [2*XLEN-1:0] bx;
    logic [2*XLEN-1:0] p;
    ax = {{XLEN{a[XLEN-1] & (f != 2'b11)}}, a};
    bx = {{XLEN{b[XLEN-1] & (f == 2'b01)}}, b};
    p  = ax * bx;
    return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction
`endif

  always_comb begin
    ill = 1'b1;
    res = '0;
    unique case (1'b1)
      is_op: begin
        if (f7 == 7'h00 ||
            (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          ill = 1'b0;
          res = alu(f3, op_a, op_b, f7[5]);
        end
`ifdef ISSUE_MUL_EN
        else if (f7 == 7'h01 && !f3[2]) begin
          ill = 1'b0;
          res = mul(f3[1:0], op_a, op_b);
        end
`endif
      end
      is_imm: begin
        if ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'h00 ||
            (f3 == 3'b101 && f7 == 7'h20)) begin
          ill = 1'b0;
          res = alu(f3, op_a, imm_i, f3 == 3'b101 && f7[5]);
        end
      end
      is_lui: begin
        ill = 1'b0;
        res = imm_u;
      end
      default: ;
    endcase
  end

  assign iq_deq    = (state == IDLE) && !iq_empty && !flush && !reset;
  assign rs1_addr  = instr[19:15];
  assign rs2_addr  = instr[24:20];
  assign wb_valid  = (state == WB);
  assign wb_rd     = rd_q;
  assign wb_data   = result;
  assign illegal   = illegal_q;
  assign busy      = (state != IDLE);
  assign issue_cnt = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      instr     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      cnt       <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!iq_empty) begin
              instr <= iq_data;
              state <= READ;
            end
          end
          READ: begin
            op_a  <= rs1_data;
            op_b  <= rs2_data;
            state <= EXEC;
          end
          EXEC: begin
            if (ill) begin
              illegal_q <= 1'b1;
              state     <= IDLE;
            end else if (rd == 5'd0) begin
              state <= IDLE;
            end else begin
              result <= res;
              rd_q   <= rd;
              state  <= WB;
            end
          end
          default: begin
            if (wb_ready) begin
              cnt   <= cnt + 32'd1;
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_issue_reader.sv
// Randomized bench for int_issue_reader with an op-level reference model.
// Define ISSUE_MUL_EN here as for the RTL to expect multiply results.
module tb_int_issue_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        iq_empty;
  logic [31:0] iq_data;
  logic        iq_deq;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [31:0] issue_cnt;

  logic [31:0] rf [32];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_cnt  = 0;

  always #5 clk = ~clk;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  int_issue_reader dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .iq_empty (iq_empty),
    .iq_data  (iq_data),
    .iq_deq   (iq_deq),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .illegal  (illegal),
    .busy     (busy),
    .issue_cnt(issue_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ops: 0-9 R-type, 10-15 I-type, 16-18 shifts-imm, 19 LUI,
  // 20-23 MUL family, 24 opcode 0x7F, 25 DIV/REM slot
  function automatic logic [31:0] enc(
    input int op, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [11:0] imm, input logic [19:0] up);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = 7'h00;
    f3 = 3'd0;
    case (op)
      1:  f7 = 7'h20;
      2:  f3 = 3'd1;
      3:  f3 = 3'd2;
      4:  f3 = 3'd3;
      5:  f3 = 3'd4;
      6:  f3 = 3'd5;
      7:  begin f7 = 7'h20; f3 = 3'd5; end
      8:  f3 = 3'd6;
      9:  f3 = 3'd7;
      11: f3 = 3'd2;
      12: f3 = 3'd3;
      13: f3 = 3'd4;
      14: f3 = 3'd6;
      15: f3 = 3'd7;
      16: f3 = 3'd1;
      17: f3 = 3'd5;
      18: begin f7 = 7'h20; f3 = 3'd5; end
      20, 21, 22, 23: begin f7 = 7'h01; f3 = 3'(op - 20); end
      25: begin f7 = 7'h01; f3 = {1'b1, imm[1:0]}; end
      default: ;
    endcase
    if (op <= 9 || (op >= 20 && op <= 23) || op == 25)
      return {f7, rs2, rs1, f3, rd, 7'h33};
    else if (op <= 15)
      return {imm, rs1, f3, rd, 7'h13};
    else if (op <= 18)
      return {f7, rs2, rs1, f3, rd, 7'h13};
    else if (op == 19)
      return {up, rd, 7'h37};
    else
      return {up, rd, 7'h7F};
  endfunction

  // For shift-immediate ops the shamt travels in the rs2 field
  function automatic void model(
    input int op, input logic [31:0] a, input logic [31:0] b,
    input logic [11:0] imm, input logic [4:0] sh, input logic [19:0] up,
    output bit legal, output logic [31:0] r);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] si;
    logic [31:0]        iv;
    longint             p;
    longint unsigned    pu;
    sa = a;
    sb = b;
    iv = {{20{imm[11]}}, imm};
    si = iv;
    legal = 1'b1;
    r = 32'd0;
    p = 0;
    pu = 0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << b[4:0];
      3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4:  r = (a < b) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = a >> b[4:0];
      7:  r = sa >>> b[4:0];
      8:  r = a | b;
      9:  r = a & b;
      10: r = a + iv;
      11: r = (sa < si) ? 32'd1 : 32'd0;
      12: r = (a < iv) ? 32'd1 : 32'd0;
      13: r = a ^ iv;
      14: r = a | iv;
      15: r = a & iv;
      16: r = a << sh;
      17: r = a >> sh;
      18: r = sa >>> sh;
      19: r = {up, 12'h000};
`ifdef ISSUE_MUL_EN
      20: r = a * b;
      21: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      22: begin p = longint'(sa) * longint'({32'h0, b}); r = p[63:32]; end
      23: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic set_regs(input logic [4:0] r1, input logic [31:0] a,
                          input logic [4:0] r2, input logic [31:0] b);
    rf[r1] = a;
    rf[r2] = b;
    if (r1 == r2) rf[r1] = b;
    rf[0] = 32'd0;
  endtask

  // Entered and left on a negedge with the queue empty and wb_ready low
  task automatic run(input string tag, input logic [31:0] word,
                     input bit legal, input logic [31:0] val, input int dly);
    logic [4:0] rd;
    rd = word[11:7];
    iq_data  = word;
    iq_empty = 1'b0;
    #1;
    chk({tag, ".deq"}, {31'd0, iq_deq}, 32'd1);
    @(negedge clk);
    iq_data  = 32'h0000_0033;
    wb_ready = 1'($urandom % 2);
    #1;
    chk({tag, ".deq_read"}, {31'd0, iq_deq}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".rs1"}, {27'd0, rs1_addr}, {27'd0, word[19:15]});
    @(negedge clk);
    iq_empty = 1'b1;
    wb_ready = 1'($urandom % 2);
    #1;
    chk({tag, ".ill_exec"}, {31'd0, illegal}, 32'd0);
    @(negedge clk);
    wb_ready = 1'b0;
    #1;
    if (!legal) begin
      chk({tag, ".illegal"}, {31'd0, illegal}, 32'd1);
      chk({tag, ".nowb"}, {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      chk({tag, ".pulse"}, {31'd0, illegal}, 32'd0);
    end else if (rd == 5'd0) begin
      chk({tag, ".nowb0"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, ".noill"}, {31'd0, illegal}, 32'd0);
      chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    end else begin
      chk({tag, ".valid"}, {31'd0, wb_valid}, 32'd1);
      chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, rd});
      chk({tag, ".data"}, wb_data, val);
      iq_empty = 1'b0;
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        #1;
        chk({tag, ".hold_v"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, ".hold_d"}, wb_data, val);
        chk({tag, ".hold_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        chk({tag, ".hold_deq"}, {31'd0, iq_deq}, 32'd0);
        chk({tag, ".hold_busy"}, {31'd0, busy}, 32'd1);
      end
      iq_empty = 1'b1;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      exp_cnt++;
      #1;
      chk({tag, ".done"}, {31'd0, wb_valid}, 32'd0);
    end
    chk({tag, ".cnt"}, issue_cnt, exp_cnt);
    @(negedge clk);
  endtask

  // stage: 2 = flush in EXEC, 3 = flush in WB with a coinciding handshake
  task automatic flush_at(input string tag, input int stage);
    set_regs(5'd1, 32'd10, 5'd2, 32'd20);
    iq_data  = enc(0, 5'd3, 5'd1, 5'd2, 12'd0, 20'd0);
    iq_empty = 1'b0;
    @(negedge clk);
    iq_empty = 1'b1;
    @(negedge clk);
    if (stage == 3) begin
      @(negedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, wb_valid}, 32'd1);
      wb_ready = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    wb_ready = 1'b0;
    #1;
    chk({tag, ".nowb"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ".cnt"}, issue_cnt, exp_cnt);
    @(negedge clk);
  endtask

  initial begin
    bit          legal;
    logic [31:0] val;
    logic [31:0] w;
    int          op;
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [11:0] imm;
    logic [19:0] up;
    logic [31:0] a;
    logic [31:0] b;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    reset    = 1'b1;
    flush    = 1'b0;
    iq_empty = 1'b0;
    iq_data  = 32'h0031_01B3;
    wb_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.deq", {31'd0, iq_deq}, 32'd0);
    iq_empty = 1'b1;
    reset    = 1'b0;
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.ill", {31'd0, illegal}, 32'd0);
    chk("rst.rd", {27'd0, wb_rd}, 32'd0);
    chk("rst.data", wb_data, 32'd0);
    chk("rst.cnt", issue_cnt, 32'd0);
    @(negedge clk);
    #1;
    chk("empty.deq", {31'd0, iq_deq}, 32'd0);
    chk("empty.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    set_regs(5'd1, 32'd5, 5'd2, 32'd7);
    run("add", enc(0, 5'd3, 5'd1, 5'd2, 12'd0, 20'd0), 1'b1, 32'd12, 0);
    set_regs(5'd1, 32'd0, 5'd2, 32'd1);
    run("sub", enc(1, 5'd4, 5'd1, 5'd2, 12'd0, 20'd0), 1'b1,
        32'hFFFF_FFFF, 0);
    set_regs(5'd6, 32'h8000_0000, 5'd0, 32'd0);
    run("srai", enc(18, 5'd5, 5'd6, 5'd4, 12'd0, 20'd0), 1'b1,
        32'hF800_0000, 0);
    set_regs(5'd1, 32'd100, 5'd2, 32'd23);
    run("stall", enc(0, 5'd9, 5'd1, 5'd2, 12'd0, 20'd0), 1'b1,
        32'd123, 5);
    run("addi_x0", enc(10, 5'd0, 5'd1, 5'd0, 12'd9, 20'd0), 1'b1,
        32'd0, 0);
    run("op7f", 32'h0000_007F, 1'b0, 32'd0, 0);

    flush_at("fl_exec", 2);
    flush_at("fl_wb", 3);
    iq_empty = 1'b0;
    flush    = 1'b1;
    #1;
    chk("fl_idle.deq", {31'd0, iq_deq}, 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    iq_empty = 1'b1;
    #1;
    chk("fl_idle.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    set_regs(5'd1, 32'd1, 5'd2, 32'd2);
    run("post_fl", enc(0, 5'd8, 5'd1, 5'd2, 12'd0, 20'd0), 1'b1, 32'd3, 1);

    set_regs(5'd1, 32'hFFFF_FFFF, 5'd2, 32'd2);
    model(20, 32'hFFFF_FFFF, 32'd2, 12'd0, 5'd0, 20'd0, legal, val);
    run("mul", enc(20, 5'd7, 5'd1, 5'd2, 12'd0, 20'd0), legal, val, 0);

    for (int n = 0; n < 80; n++) begin
      op  = int'($urandom % 26);
      rd  = 5'($urandom);
      if ($urandom % 8 == 0) rd = 5'd0;
      r1  = 5'($urandom);
      r2  = 5'($urandom);
      imm = 12'($urandom);
      up  = 20'($urandom);
      case ($urandom % 4)
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      set_regs(r1, a, r2, b);
      a = rf[r1];
      b = rf[r2];
      w = enc(op, rd, r1, r2, imm, up);
      model(op, a, b, imm, r2, up, legal, val);
      run($sformatf("rnd%0d_op%0d", n, op), w, legal, val,
          int'($urandom % 4));
    end

    set_regs(5'd1, 32'd3, 5'd2, 32'd4);
    iq_data  = enc(0, 5'd3, 5'd1, 5'd2, 12'd0, 20'd0);
    iq_empty = 1'b0;
    @(negedge clk);
    iq_empty = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    flush   = 1'b0;
    exp_cnt = 32'd0;
    #1;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst.cnt", issue_cnt, exp_cnt);
    @(negedge clk);
    run("after_rst", enc(10, 5'd11, 5'd1, 5'd0, 12'hFFF, 20'd0), 1'b1,
        32'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
